// File: rtl/metropolis_judge.sv
// ---------------------------------------------------------------------------
// metropolis_judge
//
// Metropolis acceptance unit shared by REPLICA_NUM interleaved replicas of the
// replica-exchange TSP annealer. For each move proposal it accumulates a
// signed tour-length delta from a stream of distance terms, scales it by the
// replica's inverse temperature, compares against a per-move random
// threshold, and updates the replica's stored tour length on acceptance.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   init_*            direct write of a replica's total tour length
//   cmd_*             move proposal handshake (id, opt code, threshold)
//   term_*            distance term stream (op, data, last) for the proposal
//   res_*             decision result (id, opt, accept, delta, new total)
// All outputs are registered.
// ---------------------------------------------------------------------------
module metropolis_judge #(
    parameter int REPLICA_NUM = 32,
    parameter int REP_W       = $clog2(REPLICA_NUM),
    parameter int DIST_W      = 18,
    parameter int DELTA_W     = 21,
    parameter int TOTAL_W     = 23,
    parameter int DBETA       = 5,
    parameter int THR_W       = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               init_valid,
    input  logic [REP_W-1:0]   init_id,
    input  logic [TOTAL_W-1:0] init_total,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [REP_W-1:0]   cmd_id,
    input  logic [1:0]         cmd_opt,
    input  logic [THR_W-1:0]   cmd_thresh,
    input  logic               term_valid,
    output logic               term_ready,
    input  logic [1:0]         term_op,
    input  logic [DIST_W-1:0]  term_data,
    input  logic               term_last,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [REP_W-1:0]   res_id,
    output logic [1:0]         res_opt,
    output logic               res_accept,
    output logic [DELTA_W-1:0] res_delta,
    output logic [TOTAL_W-1:0] res_total
);

    localparam int BETA_W = $clog2(DBETA * REPLICA_NUM + 1);
    localparam int PROD_W = DELTA_W + BETA_W;
    localparam int CMP_W  = (PROD_W > THR_W) ? PROD_W : THR_W;
    localparam int SUM_W  = ((TOTAL_W > DELTA_W) ? TOTAL_W : DELTA_W) + 2;

    localparam logic [1:0] OP_DNOP = 2'b00;
    localparam logic [1:0] OP_ZERO = 2'b01;
    localparam logic [1:0] OP_PLS  = 2'b10;
    localparam logic [1:0] OP_MNS  = 2'b11;

    localparam logic signed [DELTA_W-1:0] ACC_MAX = {1'b0, {(DELTA_W-1){1'b1}}};
    localparam logic signed [DELTA_W-1:0] ACC_MIN = {1'b1, {(DELTA_W-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        ACC,
        MUL,
        DEC,
        RES
    } state_t;

    state_t                     state;
    logic [REP_W-1:0]           id_q;
    logic [1:0]                 opt_q;
    logic [THR_W-1:0]           thresh_q;
    logic signed [DELTA_W-1:0]  acc_q;
    logic signed [PROD_W-1:0]   prod_q;
    logic [TOTAL_W-1:0]         totals [REPLICA_NUM];

    logic signed [DELTA_W:0]    acc_ext;
    logic signed [DELTA_W:0]    data_ext;
    logic signed [DELTA_W:0]    acc_sum;
    logic signed [DELTA_W-1:0]  acc_next;
    logic [BETA_W:0]            beta;
    logic signed [PROD_W-1:0]   prod_next;
    logic [TOTAL_W-1:0]         total_cur;
    logic signed [SUM_W-1:0]    total_sum;
    logic [TOTAL_W-1:0]         total_clamped;
    logic                       accept;

    // Next accumulator value for the term on the bus. The sum is formed one
    // bit wider than the accumulator so overflow shows up as a disagreement
    // of the top two bits, which selects the saturation limit.
    always_comb begin
        acc_ext  = $signed({acc_q[DELTA_W-1], acc_q});
        data_ext = $signed({1'b0, DELTA_W'(term_data)});
        acc_sum  = acc_ext;
        acc_next = acc_q;
        case (term_op)
            OP_PLS:  acc_sum = acc_ext + data_ext;
            OP_MNS:  acc_sum = acc_ext - data_ext;
            default: acc_sum = acc_ext;
        endcase
        if (term_op == OP_ZERO) begin
            acc_next = '0;
        end else if (term_op == OP_DNOP) begin
            acc_next = acc_q;
        end else if (acc_sum[DELTA_W] != acc_sum[DELTA_W-1]) begin
            acc_next = acc_sum[DELTA_W] ? ACC_MIN : ACC_MAX;
        end else begin
            acc_next = acc_sum[DELTA_W-1:0];
        end
    end

    // Inverse temperature of the current replica is DBETA*(id+1); it is
    // always positive, so it is zero-extended before the signed multiply.
    always_comb begin
        beta      = (BETA_W+1)'(DBETA * (int'(id_q) + 1));
        prod_next = PROD_W'(acc_q) * $signed(PROD_W'(beta));
    end

    // Decision and clamped write-back value. A non-positive delta always
    // accepts, so the threshold compare only matters when the product is
    // positive and can be done on unsigned magnitudes.
    always_comb begin
        total_cur     = totals[id_q];
        accept        = acc_q[DELTA_W-1] || (acc_q == '0) ||
                        (CMP_W'($unsigned(prod_q)) < CMP_W'(thresh_q));
        total_sum     = $signed(SUM_W'(total_cur)) + SUM_W'(acc_q);
        total_clamped = total_sum[TOTAL_W-1:0];
        if (total_sum[SUM_W-1]) begin
            total_clamped = '0;
        end else if (|total_sum[SUM_W-2:TOTAL_W]) begin
            total_clamped = '1;
        end
    end

    // Main control FSM with registered handshake and result outputs. The
    // init write is placed after the decision write-back so that an init to
    // the same replica in the same cycle takes precedence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            id_q       <= '0;
            opt_q      <= '0;
            thresh_q   <= '0;
            acc_q      <= '0;
            prod_q     <= '0;
            cmd_ready  <= 1'b0;
            term_ready <= 1'b0;
            res_valid  <= 1'b0;
            res_id     <= '0;
            res_opt    <= '0;
            res_accept <= 1'b0;
            res_delta  <= '0;
            res_total  <= '0;
            for (int i = 0; i < REPLICA_NUM; i++) begin
                totals[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_ready && cmd_valid) begin
                        id_q       <= cmd_id;
                        opt_q      <= cmd_opt;
                        thresh_q   <= cmd_thresh;
                        acc_q      <= '0;
                        cmd_ready  <= 1'b0;
                        term_ready <= 1'b1;
                        state      <= ACC;
                    end
                end
                ACC: begin
                    if (term_valid && term_ready) begin
                        acc_q <= acc_next;
                        if (term_last) begin
                            term_ready <= 1'b0;
                            state      <= MUL;
                        end
                    end
                end
                MUL: begin
                    prod_q <= prod_next;
                    state  <= DEC;
                end
                DEC: begin
                    if (accept) begin
                        totals[id_q] <= total_clamped;
                        res_total    <= total_clamped;
                    end else begin
                        res_total    <= total_cur;
                    end
                    res_id     <= id_q;
                    res_opt    <= opt_q;
                    res_accept <= accept;
                    res_delta  <= acc_q;
                    res_valid  <= 1'b1;
                    state      <= RES;
                end
                RES: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
            if (init_valid) begin
                totals[init_id] <= init_total;
            end
        end
    end

endmodule

// File: tb/tb_metropolis_judge.sv
// ---------------------------------------------------------------------------
// tb_metropolis_judge
//
// Self-checking bench for metropolis_judge: a table of directed proposals
// with hand-computed results, followed by hand-written sequences for result
// stall, init/write-back collisions, stray terms and mid-operation reset.
// ---------------------------------------------------------------------------
module tb_metropolis_judge;

    localparam int REPLICA_NUM = 32;
    localparam int REP_W       = 5;
    localparam int DIST_W      = 18;
    localparam int DELTA_W     = 21;
    localparam int TOTAL_W     = 23;
    localparam int DBETA       = 5;
    localparam int THR_W       = 32;

    localparam logic [1:0] DNOP = 2'b00;
    localparam logic [1:0] ZERO = 2'b01;
    localparam logic [1:0] PLS  = 2'b10;
    localparam logic [1:0] MNS  = 2'b11;

    logic               clk;
    logic               rst_n;
    logic               init_valid;
    logic [REP_W-1:0]   init_id;
    logic [TOTAL_W-1:0] init_total;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [REP_W-1:0]   cmd_id;
    logic [1:0]         cmd_opt;
    logic [THR_W-1:0]   cmd_thresh;
    logic               term_valid;
    logic               term_ready;
    logic [1:0]         term_op;
    logic [DIST_W-1:0]  term_data;
    logic               term_last;
    logic               res_valid;
    logic               res_ready;
    logic [REP_W-1:0]   res_id;
    logic [1:0]         res_opt;
    logic               res_accept;
    logic [DELTA_W-1:0] res_delta;
    logic [TOTAL_W-1:0] res_total;

    metropolis_judge #(
        .REPLICA_NUM(REPLICA_NUM),
        .REP_W      (REP_W),
        .DIST_W     (DIST_W),
        .DELTA_W    (DELTA_W),
        .TOTAL_W    (TOTAL_W),
        .DBETA      (DBETA),
        .THR_W      (THR_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .init_valid(init_valid),
        .init_id   (init_id),
        .init_total(init_total),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_id    (cmd_id),
        .cmd_opt   (cmd_opt),
        .cmd_thresh(cmd_thresh),
        .term_valid(term_valid),
        .term_ready(term_ready),
        .term_op   (term_op),
        .term_data (term_data),
        .term_last (term_last),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_opt   (res_opt),
        .res_accept(res_accept),
        .res_delta (res_delta),
        .res_total (res_total)
    );

    typedef struct {
        logic                do_init;
        logic [REP_W-1:0]    init_id;
        logic [TOTAL_W-1:0]  init_val;
        logic [REP_W-1:0]    id;
        logic [1:0]          opt;
        logic [THR_W-1:0]    thresh;
        int                  n;
        logic [7:0][19:0]    terms;
        logic                exp_accept;
        logic [DELTA_W-1:0]  exp_delta;
        logic [TOTAL_W-1:0]  exp_total;
    } vec_t;

    localparam int NVEC = 11;
    vec_t vecs [NVEC];

    logic [7:0][19:0] cur_terms;
    int               cur_n;
    int               checks = 0;
    int               errors = 0;

    // Free-running clock; inputs change and outputs are sampled on negedge.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net in case a handshake never completes.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string what, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", what, actual, expected);
        end
    endtask

    task automatic timeoutFail(input string what);
        checks++;
        errors++;
        $display("[TB] FAIL %s: timed out, got 0 expected 1", what);
    endtask

    task automatic issueCmd(input logic [REP_W-1:0] id, input logic [1:0] opt,
                            input logic [THR_W-1:0] thr);
        int waited = 0;
        while (!cmd_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!cmd_ready) timeoutFail("cmd_ready wait");
        cmd_valid  = 1'b1;
        cmd_id     = id;
        cmd_opt    = opt;
        cmd_thresh = thr;
        @(negedge clk);
        cmd_valid  = 1'b0;
    endtask

    task automatic driveTerm(input logic [1:0] op, input logic [DIST_W-1:0] data,
                             input logic last);
        int waited = 0;
        while (!term_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!term_ready) timeoutFail("term_ready wait");
        term_valid = 1'b1;
        term_op    = op;
        term_data  = data;
        term_last  = last;
        @(negedge clk);
        term_valid = 1'b0;
        term_last  = 1'b0;
    endtask

    task automatic sendProposal(input logic [REP_W-1:0] id, input logic [1:0] opt,
                                input logic [THR_W-1:0] thr);
        issueCmd(id, opt, thr);
        for (int k = 0; k < cur_n; k++) begin
            driveTerm(cur_terms[k][19:18], cur_terms[k][17:0], k == cur_n - 1);
        end
    endtask

    task automatic waitResult();
        int waited = 0;
        while (!res_valid && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!res_valid) timeoutFail("res_valid wait");
    endtask

    task automatic releaseResult();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic checkResult(input string tag, input logic acc, input logic [DELTA_W-1:0] dlt,
                               input logic [TOTAL_W-1:0] tot, input logic [REP_W-1:0] id,
                               input logic [1:0] opt);
        checkOutput($sformatf("%s res_accept", tag), 32'(res_accept), 32'(acc));
        checkOutput($sformatf("%s res_delta", tag), 32'(res_delta), 32'(dlt));
        checkOutput($sformatf("%s res_total", tag), 32'(res_total), 32'(tot));
        checkOutput($sformatf("%s res_id", tag), 32'(res_id), 32'(id));
        checkOutput($sformatf("%s res_opt", tag), 32'(res_opt), 32'(opt));
    endtask

    task automatic applyStimulus(input int idx);
        if (vecs[idx].do_init) begin
            init_valid = 1'b1;
            init_id    = vecs[idx].init_id;
            init_total = vecs[idx].init_val;
            @(negedge clk);
            init_valid = 1'b0;
        end
        cur_terms = vecs[idx].terms;
        cur_n     = vecs[idx].n;
        sendProposal(vecs[idx].id, vecs[idx].opt, vecs[idx].thresh);
        waitResult();
        checkResult($sformatf("vec%0d", idx), vecs[idx].exp_accept, vecs[idx].exp_delta,
                    vecs[idx].exp_total, vecs[idx].id, vecs[idx].opt);
        releaseResult();
    endtask

    task automatic singleTerm(input logic [1:0] op, input logic [DIST_W-1:0] data);
        cur_terms    = '0;
        cur_terms[0] = {op, data};
        cur_n        = 1;
    endtask

    initial begin
        rst_n      = 1'b0;
        init_valid = 1'b0;
        init_id    = '0;
        init_total = '0;
        cmd_valid  = 1'b0;
        cmd_id     = '0;
        cmd_opt    = '0;
        cmd_thresh = '0;
        term_valid = 1'b0;
        term_op    = '0;
        term_data  = '0;
        term_last  = 1'b0;
        res_ready  = 1'b0;

        // Directed vector table, each with hand-computed results.
        vecs[0] = '{do_init:1'b1, init_id:5'd3, init_val:23'h010000, id:5'd3, opt:2'd1,
                    thresh:32'h0, n:2, terms:'0, exp_accept:1'b1,
                    exp_delta:21'h1FC000, exp_total:23'h00C000};
        vecs[0].terms[0] = {PLS, 18'h08000};
        vecs[0].terms[1] = {MNS, 18'h0C000};
        vecs[1] = '{do_init:1'b0, init_id:5'd0, init_val:23'h0, id:5'd0, opt:2'd2,
                    thresh:32'h30000, n:1, terms:'0, exp_accept:1'b1,
                    exp_delta:21'h008000, exp_total:23'h008000};
        vecs[1].terms[0] = {PLS, 18'h08000};
        vecs[2] = '{do_init:1'b0, init_id:5'd0, init_val:23'h0, id:5'd0, opt:2'd3,
                    thresh:32'h28000, n:1, terms:'0, exp_accept:1'b0,
                    exp_delta:21'h008000, exp_total:23'h008000};
        vecs[2].terms[0] = {PLS, 18'h08000};
        vecs[3] = '{do_init:1'b0, init_id:5'd0, init_val:23'h0, id:5'd3, opt:2'd0,
                    thresh:32'h0, n:2, terms:'0, exp_accept:1'b1,
                    exp_delta:21'h0, exp_total:23'h00C000};
        vecs[3].terms[0] = {PLS, 18'h01234};
        vecs[3].terms[1] = {MNS, 18'h01234};
        vecs[4] = '{do_init:1'b0, init_id:5'd0, init_val:23'h0, id:5'd3, opt:2'd1,
                    thresh:32'h0, n:1, terms:'0, exp_accept:1'b0,
                    exp_delta:21'h1, exp_total:23'h00C000};
        vecs[4].terms[0] = {PLS, 18'h00001};
        vecs[5] = '{do_init:1'b1, init_id:5'd1, init_val:23'h7F0000, id:5'd1, opt:2'd2,
                    thresh:32'hFFFFFFFF, n:8, terms:'0, exp_accept:1'b1,
                    exp_delta:21'h0FFFFF, exp_total:23'h7FFFFF};
        for (int k = 0; k < 8; k++) vecs[5].terms[k] = {PLS, 18'h3FFFF};
        vecs[6] = '{do_init:1'b0, init_id:5'd0, init_val:23'h0, id:5'd2, opt:2'd3,
                    thresh:32'hFFFFFFFF, n:3, terms:'0, exp_accept:1'b1,
                    exp_delta:21'h20, exp_total:23'h20};
        vecs[6].terms[0] = {PLS, 18'h00100};
        vecs[6].terms[1] = {ZERO, 18'h00000};
        vecs[6].terms[2] = {PLS, 18'h00020};
        vecs[7] = '{do_init:1'b0, init_id:5'd0, init_val:23'h0, id:5'd4, opt:2'd0,
                    thresh:32'h0, n:8, terms:'0, exp_accept:1'b1,
                    exp_delta:21'h100000, exp_total:23'h0};
        for (int k = 0; k < 8; k++) vecs[7].terms[k] = {MNS, 18'h3FFFF};
        vecs[8] = '{do_init:1'b0, init_id:5'd0, init_val:23'h0, id:5'd2, opt:2'd1,
                    thresh:32'hFFFFFFFF, n:2, terms:'0, exp_accept:1'b1,
                    exp_delta:21'h5, exp_total:23'h25};
        vecs[8].terms[0] = {DNOP, 18'h3FFFF};
        vecs[8].terms[1] = {PLS, 18'h00005};
        vecs[9] = '{do_init:1'b0, init_id:5'd0, init_val:23'h0, id:5'd31, opt:2'd2,
                    thresh:32'h0000A001, n:1, terms:'0, exp_accept:1'b1,
                    exp_delta:21'h100, exp_total:23'h100};
        vecs[9].terms[0] = {PLS, 18'h00100};
        vecs[10] = '{do_init:1'b0, init_id:5'd0, init_val:23'h0, id:5'd31, opt:2'd3,
                     thresh:32'h0000A000, n:1, terms:'0, exp_accept:1'b0,
                     exp_delta:21'h100, exp_total:23'h100};
        vecs[10].terms[0] = {PLS, 18'h00100};

        // Reset state of every output.
        repeat (2) @(negedge clk);
        checkOutput("reset cmd_ready", 32'(cmd_ready), 32'd0);
        checkOutput("reset term_ready", 32'(term_ready), 32'd0);
        checkOutput("reset res_valid", 32'(res_valid), 32'd0);
        checkOutput("reset res_accept", 32'(res_accept), 32'd0);
        checkOutput("reset res_delta", 32'(res_delta), 32'd0);
        checkOutput("reset res_total", 32'(res_total), 32'd0);
        checkOutput("reset res_id", 32'(res_id), 32'd0);
        checkOutput("reset res_opt", 32'(res_opt), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle cmd_ready", 32'(cmd_ready), 32'd1);

        for (int i = 0; i < NVEC; i++) applyStimulus(i);

        // Stray terms while idle must not be taken.
        term_valid = 1'b1;
        term_op    = PLS;
        term_data  = 18'h3FFFF;
        term_last  = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checkOutput("idle term_ready", 32'(term_ready), 32'd0);
        end
        checkOutput("idle stays idle", 32'(cmd_ready), 32'd1);
        term_valid = 1'b0;
        term_last  = 1'b0;

        // Result stall: held fields, no cmd_ready, init to same id ignored by res_total.
        singleTerm(PLS, 18'h00010);
        sendProposal(5'd2, 2'd2, 32'hFFFFFFFF);
        waitResult();
        for (int c = 0; c < 5; c++) begin
            if (c == 1) begin
                init_valid = 1'b1;
                init_id    = 5'd2;
                init_total = 23'h000999;
            end else begin
                init_valid = 1'b0;
            end
            @(negedge clk);
            checkOutput($sformatf("stall%0d res_valid", c), 32'(res_valid), 32'd1);
            checkOutput($sformatf("stall%0d cmd_ready", c), 32'(cmd_ready), 32'd0);
            checkOutput($sformatf("stall%0d res_total", c), 32'(res_total), 32'h35);
            checkOutput($sformatf("stall%0d res_delta", c), 32'(res_delta), 32'h10);
        end
        init_valid = 1'b0;
        releaseResult();
        singleTerm(DNOP, 18'h0);
        sendProposal(5'd2, 2'd0, 32'h0);
        waitResult();
        checkResult("after stall init", 1'b1, 21'h0, 23'h000999, 5'd2, 2'd0);
        releaseResult();

        // Init colliding with the decision write-back on the same replica.
        singleTerm(PLS, 18'h00040);
        sendProposal(5'd5, 2'd1, 32'hFFFFFFFF);
        checkOutput("latency MUL res_valid", 32'(res_valid), 32'd0);
        @(negedge clk);
        checkOutput("latency DEC res_valid", 32'(res_valid), 32'd0);
        init_valid = 1'b1;
        init_id    = 5'd5;
        init_total = 23'h000777;
        @(negedge clk);
        init_valid = 1'b0;
        checkOutput("latency RES res_valid", 32'(res_valid), 32'd1);
        checkResult("dec collide", 1'b1, 21'h40, 23'h40, 5'd5, 2'd1);
        releaseResult();
        singleTerm(DNOP, 18'h0);
        sendProposal(5'd5, 2'd2, 32'h0);
        waitResult();
        checkResult("after collide", 1'b1, 21'h0, 23'h000777, 5'd5, 2'd2);
        releaseResult();

        // Reset while accumulating, with term_valid idle for a cycle first.
        issueCmd(5'd3, 2'd1, 32'hFFFFFFFF);
        driveTerm(PLS, 18'h00100, 1'b0);
        @(negedge clk);
        checkOutput("acc hold term_ready", 32'(term_ready), 32'd1);
        checkOutput("acc hold res_valid", 32'(res_valid), 32'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("acc reset term_ready", 32'(term_ready), 32'd0);
        checkOutput("acc reset cmd_ready", 32'(cmd_ready), 32'd0);
        checkOutput("acc reset res_valid", 32'(res_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset while a result is being held.
        singleTerm(PLS, 18'h00007);
        sendProposal(5'd6, 2'd3, 32'hFFFFFFFF);
        waitResult();
        checkOutput("res before reset", 32'(res_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("res reset res_valid", 32'(res_valid), 32'd0);
        checkOutput("res reset res_total", 32'(res_total), 32'd0);
        checkOutput("res reset res_delta", 32'(res_delta), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Totals cleared by reset.
        singleTerm(DNOP, 18'h0);
        sendProposal(5'd3, 2'd0, 32'h0);
        waitResult();
        checkResult("post reset id3", 1'b1, 21'h0, 23'h0, 5'd3, 2'd0);
        releaseResult();
        singleTerm(DNOP, 18'h0);
        sendProposal(5'd1, 2'd1, 32'h0);
        waitResult();
        checkResult("post reset id1", 1'b1, 21'h0, 23'h0, 5'd1, 2'd1);
        releaseResult();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
